// File: rtl/mem_test_multi_ch_ctrl.sv
// Kernel-level launch/complete sequencer for NUM_CH memory-channel engines.
// Parallel or sequential launch, sticky per-channel done, run-cycle counter and watchdog.
module mem_test_multi_ch_ctrl #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_WIDTH = 48,
   parameter int unsigned TMO_WIDTH = 32
) (
   input  logic                 ap_clk,
   input  logic                 areset,
   input  logic                 ap_start,
   output logic                 ap_idle,
   output logic                 ap_done,
   output logic                 ap_ready,
   input  logic [NUM_CH-1:0]    ch_enable,
   input  logic                 seq_mode,
   input  logic [TMO_WIDTH-1:0] timeout_cycles,
   output logic [NUM_CH-1:0]    ch_start,
   input  logic [NUM_CH-1:0]    ch_done,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 timed_out,
   output logic [NUM_CH-1:0]    ch_done_status
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CMP_W = (CNT_WIDTH > TMO_WIDTH) ? CNT_WIDTH : TMO_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               state;
   logic                 ap_start_q;
   logic [NUM_CH-1:0]    en_q;
   logic                 mode_q;
   logic [TMO_WIDTH-1:0] tmo_q;
   logic [IDX_W-1:0]     ptr;

   logic                 start_pulse;
   logic [NUM_CH-1:0]    status_nxt;
   logic                 complete;
   logic                 tmo_hit;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [IDX_W-1:0]     first_idx;
   logic [IDX_W-1:0]     next_idx;

   // Completion, watchdog and channel-pointer lookahead for the current cycle
   always_comb begin
      start_pulse = ap_start & ~ap_start_q;
      status_nxt  = ch_done_status | (ch_done & en_q);
      complete    = (status_nxt == en_q);
      cnt_inc     = (&cycle_count) ? cycle_count : cycle_count + CNT_WIDTH'(1);
      // >= rather than == so a limit of 1 still fires on the first RUN cycle
      tmo_hit     = (tmo_q != '0) &&
                    (CMP_W'(cycle_count) >= CMP_W'(tmo_q - TMO_WIDTH'(1)));
      first_idx   = '0;
      next_idx    = ptr;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (ch_enable[i]) first_idx = IDX_W'(i);
         if (en_q[i] && (i > int'(ptr))) next_idx = IDX_W'(i);
      end
   end

   assign ap_ready = ap_done;

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state          <= IDLE;
         ap_start_q     <= 1'b0;
         ap_idle        <= 1'b1;
         ap_done        <= 1'b0;
         ch_start       <= '0;
         cycle_count    <= '0;
         timed_out      <= 1'b0;
         ch_done_status <= '0;
         en_q           <= '0;
         mode_q         <= 1'b0;
         tmo_q          <= '0;
         ptr            <= '0;
      end else begin
         ap_start_q <= ap_start;
         ch_start   <= '0;
         ap_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_pulse) begin
                  en_q           <= ch_enable;
                  mode_q         <= seq_mode;
                  tmo_q          <= timeout_cycles;
                  cycle_count    <= '0;
                  timed_out      <= 1'b0;
                  ch_done_status <= '0;
                  ap_idle        <= 1'b0;
                  if (ch_enable == '0) begin
                     state   <= DONE;
                     ap_done <= 1'b1;
                  end else begin
                     state    <= LAUNCH;
                     ptr      <= first_idx;
                     ch_start <= seq_mode ? (NUM_CH'(1) << first_idx) : ch_enable;
                  end
               end
            end
            LAUNCH: begin
               cycle_count <= cnt_inc;
               state       <= RUN;
            end
            RUN: begin
               cycle_count    <= cnt_inc;
               ch_done_status <= status_nxt;
               if (complete) begin
                  state   <= DONE;
                  ap_done <= 1'b1;
               end else if (tmo_hit) begin
                  state     <= DONE;
                  ap_done   <= 1'b1;
                  timed_out <= 1'b1;
               end else if (mode_q && ch_done[ptr]) begin
                  ptr      <= next_idx;
                  ch_start <= NUM_CH'(1) << next_idx;
               end
            end
            DONE: begin
               ap_idle <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_test_multi_ch_ctrl.sv
// Directed bench for mem_test_multi_ch_ctrl: launch modes, completion, watchdog, reset.
// Period p of a scenario: inputs driven in p are sampled at its closing edge; outputs seen in p+1.
module tb_mem_test_multi_ch_ctrl;

   logic        ap_clk = 1'b0;
   logic        areset;
   logic        ap_start;
   logic        ap_idle;
   logic        ap_done;
   logic        ap_ready;
   logic [3:0]  ch_enable;
   logic        seq_mode;
   logic [31:0] timeout_cycles;
   logic [3:0]  ch_start;
   logic [3:0]  ch_done;
   logic [47:0] cycle_count;
   logic        timed_out;
   logic [3:0]  ch_done_status;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int base     = 0;

   int         start_p[$];
   logic [3:0] start_v[$];
   int         done_p[$];

   mem_test_multi_ch_ctrl #(.NUM_CH(4), .CNT_WIDTH(48), .TMO_WIDTH(32)) dut (
      .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle),
      .ap_done(ap_done), .ap_ready(ap_ready), .ch_enable(ch_enable), .seq_mode(seq_mode),
      .timeout_cycles(timeout_cycles), .ch_start(ch_start), .ch_done(ch_done),
      .cycle_count(cycle_count), .timed_out(timed_out), .ch_done_status(ch_done_status)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   // Event log of start and done pulses, stamped with scenario-relative period
   always @(negedge ap_clk) begin
      if (ch_start != 4'b0) begin
         start_p.push_back(cyc - base);
         start_v.push_back(ch_start);
      end
      if (ap_done) done_p.push_back(cyc - base);
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic clear_logs();
      base = cyc;
      start_p.delete();
      start_v.delete();
      done_p.delete();
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic logic [3:0] vat(input logic [3:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 4'bxxxx;
   endfunction

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({ap_idle, ap_done, ap_ready, ch_start, timed_out, ch_done_status} !== 12'b1_0_0_0000_0_0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got idle=%b done=%b ready=%b start=%b to=%b st=%b", ap_idle, ap_done, ap_ready, ch_start, timed_out, ch_done_status);
      end
      n_checks++;
      if (cycle_count !== 48'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
      areset = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_release: got idle=%b done=%b expected 1 0", ap_idle, ap_done); end
   endtask

   task automatic test_parallel();
      clear_logs();
      ch_enable = 4'b1111; seq_mode = 1'b0; timeout_cycles = 32'd0;
      for (int p = 0; p < 90; p++) begin
         if (p == 81) begin
            n_checks++;
            if (ap_idle !== 1'b0 || ap_ready !== 1'b1) begin n_fail++; $display("FAIL par_p81: got idle=%b ready=%b expected 0 1", ap_idle, ap_ready); end
         end
         if (p == 82) begin
            n_checks++;
            if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL par_idle82: got %b expected 1", ap_idle); end
         end
         ap_start = (p >= 10 && p < 15);
         ch_done  = (p == 50) ? 4'b0001 : (p == 62) ? 4'b0110 : (p == 80) ? 4'b1000 : 4'b0000;
         tick();
      end
      n_checks++;
      if (start_p.size() != 1 || qat(start_p, 0) != 11 || vat(start_v, 0) !== 4'b1111) begin
         n_fail++; $display("FAIL par_start: got n=%0d at=%0d val=%b expected 1 at 11 val 1111", start_p.size(), qat(start_p, 0), vat(start_v, 0));
      end
      n_checks++;
      if (done_p.size() != 1 || qat(done_p, 0) != 81) begin n_fail++; $display("FAIL par_done: got n=%0d at=%0d expected 1 at 81", done_p.size(), qat(done_p, 0)); end
      n_checks++;
      if (cycle_count !== 48'd70 || timed_out !== 1'b0 || ch_done_status !== 4'b1111) begin
         n_fail++; $display("FAIL par_result: got cnt=%0d to=%b st=%b expected 70 0 1111", cycle_count, timed_out, ch_done_status);
      end
   endtask

   task automatic test_sequential();
      clear_logs();
      ch_enable = 4'b1010; seq_mode = 1'b1; timeout_cycles = 32'd0;
      for (int p = 0; p < 50; p++) begin
         ap_start = (p < 3);
         ch_done  = (p == 20) ? 4'b0010 : (p == 40) ? 4'b1000 : 4'b0000;
         tick();
      end
      n_checks++;
      if (start_p.size() != 2 || qat(start_p, 0) != 1 || vat(start_v, 0) !== 4'b0010 ||
          qat(start_p, 1) != 21 || vat(start_v, 1) !== 4'b1000) begin
         n_fail++; $display("FAIL seq_starts: got n=%0d %0d:%b %0d:%b expected 1:0010 21:1000", start_p.size(), qat(start_p, 0), vat(start_v, 0), qat(start_p, 1), vat(start_v, 1));
      end
      n_checks++;
      if (qat(done_p, 0) != 41 || cycle_count !== 48'd40 || ch_done_status !== 4'b1010) begin
         n_fail++; $display("FAIL seq_result: got done=%0d cnt=%0d st=%b expected 41 40 1010", qat(done_p, 0), cycle_count, ch_done_status);
      end
   endtask

   task automatic test_empty_mask();
      clear_logs();
      ch_enable = 4'b0000; seq_mode = 1'b0; timeout_cycles = 32'd0;
      for (int p = 0; p < 12; p++) begin
         if (p == 5 || p == 7) begin
            n_checks++;
            if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL empty_idle_p%0d: got %b expected 1", p, ap_idle); end
         end
         if (p == 6) begin
            n_checks++;
            if (ap_idle !== 1'b0) begin n_fail++; $display("FAIL empty_idle_done: got %b expected 0", ap_idle); end
         end
         ap_start = (p >= 5 && p < 8);
         ch_done  = 4'b0000;
         tick();
      end
      n_checks++;
      if (start_p.size() != 0 || done_p.size() != 1 || qat(done_p, 0) != 6 || cycle_count !== 48'd0) begin
         n_fail++; $display("FAIL empty_result: got starts=%0d dones=%0d at=%0d cnt=%0d expected 0 1 6 0", start_p.size(), done_p.size(), qat(done_p, 0), cycle_count);
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      ch_enable = 4'b0011; seq_mode = 1'b0; timeout_cycles = 32'd30;
      for (int p = 0; p < 40; p++) begin
         ap_start = (p < 2);
         ch_done  = (p == 10) ? 4'b0001 : 4'b0000;
         tick();
      end
      n_checks++;
      if (qat(done_p, 0) != 31 || done_p.size() != 1) begin n_fail++; $display("FAIL tmo_done: got n=%0d at=%0d expected 1 at 31", done_p.size(), qat(done_p, 0)); end
      n_checks++;
      if (timed_out !== 1'b1 || ch_done_status !== 4'b0001 || cycle_count !== 48'd30) begin
         n_fail++; $display("FAIL tmo_result: got to=%b st=%b cnt=%0d expected 1 0001 30", timed_out, ch_done_status, cycle_count);
      end
   endtask

   task automatic test_timeout_coincide();
      clear_logs();
      ch_enable = 4'b0001; seq_mode = 1'b0; timeout_cycles = 32'd30;
      for (int p = 0; p < 40; p++) begin
         ap_start = (p < 2);
         ch_done  = (p == 30) ? 4'b0001 : 4'b0000;
         tick();
      end
      n_checks++;
      if (qat(done_p, 0) != 31 || timed_out !== 1'b0 || ch_done_status !== 4'b0001) begin
         n_fail++; $display("FAIL coincide: got done=%0d to=%b st=%b expected 31 0 0001", qat(done_p, 0), timed_out, ch_done_status);
      end
   endtask

   task automatic test_spurious();
      clear_logs();
      ch_enable = 4'b0001; seq_mode = 1'b0; timeout_cycles = 32'd0;
      for (int p = 0; p < 20; p++) begin
         ap_start = (p < 2);
         case (p)
            1:       ch_done = 4'b0001;
            5:       ch_done = 4'b0100;
            12, 13:  ch_done = 4'b0001;
            15:      ch_done = 4'b1111;
            default: ch_done = 4'b0000;
         endcase
         tick();
      end
      n_checks++;
      if (done_p.size() != 1 || qat(done_p, 0) != 13 || cycle_count !== 48'd12) begin
         n_fail++; $display("FAIL spur_done: got n=%0d at=%0d cnt=%0d expected 1 13 12", done_p.size(), qat(done_p, 0), cycle_count);
      end
      n_checks++;
      if (ch_done_status !== 4'b0001) begin n_fail++; $display("FAIL spur_status: got %b expected 0001", ch_done_status); end
   endtask

   task automatic test_held_start();
      clear_logs();
      seq_mode = 1'b0; timeout_cycles = 32'd0;
      for (int p = 0; p < 220; p++) begin
         if (p == 205) begin
            n_checks++;
            if (ch_done_status !== 4'b0000) begin n_fail++; $display("FAIL held_clear: got %b expected 0000", ch_done_status); end
         end
         ap_start  = (p < 200) || (p >= 202 && p < 205);
         ch_enable = (p < 150) ? 4'b0001 : 4'b0010;
         ch_done   = (p == 10) ? 4'b0001 : (p == 210) ? 4'b0010 : 4'b0000;
         tick();
      end
      n_checks++;
      if (start_p.size() != 2 || qat(start_p, 0) != 1 || vat(start_v, 0) !== 4'b0001 ||
          qat(start_p, 1) != 203 || vat(start_v, 1) !== 4'b0010) begin
         n_fail++; $display("FAIL held_starts: got n=%0d %0d:%b %0d:%b expected 1:0001 203:0010", start_p.size(), qat(start_p, 0), vat(start_v, 0), qat(start_p, 1), vat(start_v, 1));
      end
      n_checks++;
      if (done_p.size() != 2 || qat(done_p, 0) != 11 || qat(done_p, 1) != 211) begin
         n_fail++; $display("FAIL held_dones: got n=%0d %0d %0d expected 2 11 211", done_p.size(), qat(done_p, 0), qat(done_p, 1));
      end
      n_checks++;
      if (ch_done_status !== 4'b0010 || cycle_count !== 48'd8) begin
         n_fail++; $display("FAIL held_result: got st=%b cnt=%0d expected 0010 8", ch_done_status, cycle_count);
      end
   endtask

   task automatic test_reset_midrun();
      clear_logs();
      seq_mode = 1'b1; timeout_cycles = 32'd0;
      for (int p = 0; p < 65; p++) begin
         if (p == 16) begin
            n_checks++;
            if (ap_idle !== 1'b1 || ch_start !== 4'b0 || cycle_count !== 48'd0 ||
                ch_done_status !== 4'b0 || timed_out !== 1'b0 || ap_done !== 1'b0) begin
               n_fail++; $display("FAIL rst_mid_out: got idle=%b start=%b cnt=%0d st=%b to=%b done=%b expected 1 0000 0 0000 0 0", ap_idle, ch_start, cycle_count, ch_done_status, timed_out, ap_done);
            end
         end
         areset    = (p == 15);
         ap_start  = (p < 3) || (p >= 45 && p < 47);
         ch_enable = (p < 30) ? 4'b1010 : 4'b0100;
         case (p)
            5:       ch_done = 4'b0010;
            20:      ch_done = 4'b1000;
            55:      ch_done = 4'b0100;
            default: ch_done = 4'b0000;
         endcase
         tick();
      end
      n_checks++;
      if (start_p.size() != 3 || qat(start_p, 1) != 6 || vat(start_v, 1) !== 4'b1000 ||
          qat(start_p, 2) != 46 || vat(start_v, 2) !== 4'b0100) begin
         n_fail++; $display("FAIL rst_mid_starts: got n=%0d %0d:%b %0d:%b expected 3 6:1000 46:0100", start_p.size(), qat(start_p, 1), vat(start_v, 1), qat(start_p, 2), vat(start_v, 2));
      end
      n_checks++;
      if (done_p.size() != 1 || qat(done_p, 0) != 56 || cycle_count !== 48'd10) begin
         n_fail++; $display("FAIL rst_mid_done: got n=%0d at=%0d cnt=%0d expected 1 56 10", done_p.size(), qat(done_p, 0), cycle_count);
      end
   endtask

   initial begin
      areset = 1'b1; ap_start = 1'b0; ch_enable = 4'b0; seq_mode = 1'b0;
      timeout_cycles = 32'd0; ch_done = 4'b0;
      test_reset();
      test_parallel();
      test_sequential();
      test_empty_mask();
      test_timeout();
      test_timeout_coincide();
      test_spurious();
      test_held_start();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
